// File: rtl/keypad_loader_pkg.sv
// Shared types for the microwave keypad loader: control states, BCD digit
// type and the encoder's "no key pressed" code.
package keypad_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        COOK,
        PAUSE,
        DONE
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t NO_KEY = 4'hF;

endpackage

// File: rtl/keypad_loader_key_debounce.sv
// Two-flop synchronizer plus stability counter. A non-idle value that holds
// for DEBOUNCE_CYCLES cycles is accepted once; the idle value must then hold
// for DEBOUNCE_CYCLES cycles before the next accept is allowed.
module key_debounce
    import keypad_loader_pkg::*;
#(
    parameter int unsigned    W               = 1,
    parameter int unsigned    DEBOUNCE_CYCLES = 16,
    parameter logic [W-1:0]   IDLE_VALUE      = '0
) (
    input  logic         clock,
    input  logic         clrn,
    input  logic [W-1:0] raw,
    output logic [W-1:0] value,
    output logic         accept
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [W-1:0]  sync1;
    logic [W-1:0]  sync2;
    logic [W-1:0]  prev;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          stable;

    // cnt = number of consecutive cycles sync2 has matched prev (saturating)
    assign stable = (cnt == CW'(DEBOUNCE_CYCLES));

    always_ff @(posedge clock) begin
        if (!clrn) begin
            sync1  <= IDLE_VALUE;
            sync2  <= IDLE_VALUE;
            prev   <= IDLE_VALUE;
            cnt    <= '0;
            armed  <= 1'b0;
            value  <= IDLE_VALUE;
            accept <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            accept <= 1'b0;

            if (sync2 != prev) begin
                prev <= sync2;
                cnt  <= CW'(1);
            end else if (!stable) begin
                cnt <= cnt + CW'(1);
            end

            if (stable) begin
                if (prev == IDLE_VALUE) begin
                    armed <= 1'b1;
                    value <= IDLE_VALUE;
                end else if (armed) begin
                    armed  <= 1'b0;
                    accept <= 1'b1;
                    value  <= prev;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_loader.sv
// Keypad front end for the BCD countdown timer: encodes and debounces digits,
// shifts them into the timer, and runs the cook control flow and 1 s tick.
module keypad_loader
    import keypad_loader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TICK_DIV        = 1000,
    parameter int unsigned MAX_DIGITS      = 3
) (
    input  logic       clock,
    input  logic       clrn,
    input  logic [9:0] keys,
    input  logic       start_n,
    input  logic       stop_n,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] data,
    output logic       loadn,
    output logic       timer_clrn,
    output logic       en,
    output logic       cooking,
    output logic       done
);

    localparam int unsigned PW  = $clog2(TICK_DIV);
    localparam int unsigned CNW = $clog2(MAX_DIGITS + 1);

    state_t         state, state_n;
    bcd_t           data_n;
    logic           loadn_n, timer_clrn_n, en_n;
    logic [CNW-1:0] count, count_n;
    logic [PW-1:0]  presc, presc_n;
    logic           clear;

    bcd_t           key_code;
    bcd_t           key_value;
    logic           key_evt, start_evt, stop_evt;
    logic [1:0]     unused_levels;
    logic           door_q1, door_q2;

    always_comb begin
        key_code = NO_KEY;
        for (int unsigned i = 0; i < 10; i++) begin
            if (keys[i] && key_code == NO_KEY) key_code = bcd_t'(i);
        end
    end

    key_debounce #(
        .W               (4),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE_VALUE      (NO_KEY)
    ) u_key_db (
        .clock  (clock),
        .clrn   (clrn),
        .raw    (key_code),
        .value  (key_value),
        .accept (key_evt)
    );

    key_debounce #(
        .W               (1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE_VALUE      (1'b1)
    ) u_start_db (
        .clock  (clock),
        .clrn   (clrn),
        .raw    (start_n),
        .value  (unused_levels[0]),
        .accept (start_evt)
    );

    key_debounce #(
        .W               (1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .IDLE_VALUE      (1'b1)
    ) u_stop_db (
        .clock  (clock),
        .clrn   (clrn),
        .raw    (stop_n),
        .value  (unused_levels[1]),
        .accept (stop_evt)
    );

    always_comb begin
        state_n      = state;
        data_n       = data;
        loadn_n      = 1'b1;
        timer_clrn_n = 1'b1;
        en_n         = 1'b0;
        count_n      = count;
        presc_n      = presc;
        clear        = 1'b0;

        unique case (state)
            IDLE, ENTRY: begin
                if (stop_evt) begin
                    clear = 1'b1;
                end else if (state == ENTRY && start_evt && door_q2 && !timer_zero) begin
                    state_n = COOK;
                    presc_n = '0;
                end else if (key_evt) begin
                    state_n = ENTRY;
                    if (count < CNW'(MAX_DIGITS)) begin
                        data_n  = key_value;
                        loadn_n = 1'b0;
                        count_n = count + CNW'(1);
                    end
                end
            end
            COOK: begin
                // Pausing leaves presc untouched so a resume finishes the partial second
                if (stop_evt || !door_q2) begin
                    state_n = PAUSE;
                end else if (timer_zero) begin
                    state_n = DONE;
                end else if (presc == PW'(TICK_DIV - 1)) begin
                    presc_n = '0;
                    en_n    = 1'b1;
                end else begin
                    presc_n = presc + PW'(1);
                end
            end
            PAUSE: begin
                if (stop_evt) begin
                    clear = 1'b1;
                end else if (start_evt && door_q2) begin
                    state_n = COOK;
                end
            end
            DONE: begin
                if (key_evt || start_evt || stop_evt || !door_q2) clear = 1'b1;
            end
            default: state_n = IDLE;
        endcase

        if (clear) begin
            state_n      = IDLE;
            timer_clrn_n = 1'b0;
            count_n      = '0;
            data_n       = '0;
            presc_n      = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!clrn) begin
            state      <= IDLE;
            data       <= '0;
            loadn      <= 1'b1;
            timer_clrn <= 1'b0;
            en         <= 1'b0;
            count      <= '0;
            presc      <= '0;
            door_q1    <= 1'b0;
            door_q2    <= 1'b0;
        end else begin
            state      <= state_n;
            data       <= data_n;
            loadn      <= loadn_n;
            timer_clrn <= timer_clrn_n;
            en         <= en_n;
            count      <= count_n;
            presc      <= presc_n;
            door_q1    <= door_closed;
            door_q2    <= door_q1;
        end
    end

    assign cooking = (state == COOK);
    assign done    = (state == DONE);

endmodule

// File: tb/tb_keypad_loader.sv
// Directed bench for keypad_loader with short debounce and tick periods.
module tb_keypad_loader;

    logic       clock;
    logic       clrn;
    logic [9:0] keys;
    logic       start_n;
    logic       stop_n;
    logic       door_closed;
    logic       timer_zero;
    logic [3:0] data;
    logic       loadn;
    logic       timer_clrn;
    logic       en;
    logic       cooking;
    logic       done;

    int checks = 0;
    int errors = 0;

    keypad_loader #(
        .DEBOUNCE_CYCLES (4),
        .TICK_DIV        (10),
        .MAX_DIGITS      (3)
    ) dut (
        .clock       (clock),
        .clrn        (clrn),
        .keys        (keys),
        .start_n     (start_n),
        .stop_n      (stop_n),
        .door_closed (door_closed),
        .timer_zero  (timer_zero),
        .data        (data),
        .loadn       (loadn),
        .timer_clrn  (timer_clrn),
        .en          (en),
        .cooking     (cooking),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [9:0] keys;
        logic       stop;
        int         hold;
        int         loads;
        logic [3:0] dat;
        int         clears;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_en(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            n++;
            if (en) break;
        end
    endtask

    task automatic press_start(output int seen);
        seen = 0;
        start_n = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (cooking) begin
                seen = 1;
                break;
            end
        end
        start_n = 1'b1;
    endtask

    initial begin
        int loads, clears, n, seen, en_cnt;
        logic [3:0] pdata;

        tbl[0] = '{10'b0000100000, 1'b0, 10, 1, 4'd5, 0};
        tbl[1] = '{10'b0000001000, 1'b0, 10, 1, 4'd3, 0};
        tbl[2] = '{10'b0010000000, 1'b0,  2, 0, 4'd3, 0};
        tbl[3] = '{10'b0000000000, 1'b1, 10, 0, 4'd0, 1};
        tbl[4] = '{10'b0000000010, 1'b0, 10, 1, 4'd1, 0};
        tbl[5] = '{10'b0000000100, 1'b0, 10, 1, 4'd2, 0};
        tbl[6] = '{10'b0000001000, 1'b0, 10, 1, 4'd3, 0};
        tbl[7] = '{10'b0000010000, 1'b0, 10, 0, 4'd3, 0};
        tbl[8] = '{10'b0000000000, 1'b1, 10, 0, 4'd0, 1};
        tbl[9] = '{10'b0000100100, 1'b0, 10, 1, 4'd2, 0};

        clrn        = 1'b0;
        keys        = '0;
        start_n     = 1'b1;
        stop_n      = 1'b1;
        door_closed = 1'b1;
        timer_zero  = 1'b0;

        repeat (3) @(negedge clock);
        check("rst_loadn", int'(loadn), 1);
        check("rst_en", int'(en), 0);
        check("rst_cooking", int'(cooking), 0);
        check("rst_done", int'(done), 0);
        check("rst_timer_clrn", int'(timer_clrn), 0);
        check("rst_data", int'(data), 0);
        clrn = 1'b1;
        @(negedge clock);
        check("post_rst_timer_clrn", int'(timer_clrn), 1);
        repeat (10) @(negedge clock);

        for (int unsigned i = 0; i < 10; i++) begin
            loads  = 0;
            clears = 0;
            pdata  = 4'hF;
            if (tbl[i].stop) stop_n = 1'b0;
            else             keys   = tbl[i].keys;
            for (int c = 0; c < tbl[i].hold + 12; c++) begin
                @(negedge clock);
                if (!loadn) begin
                    loads++;
                    pdata = data;
                end
                if (!timer_clrn) clears++;
                if (c == tbl[i].hold - 1) begin
                    keys   = '0;
                    stop_n = 1'b1;
                end
            end
            check($sformatf("vec%0d_loads", i), loads, tbl[i].loads);
            check($sformatf("vec%0d_clears", i), clears, tbl[i].clears);
            check($sformatf("vec%0d_data_end", i), int'(data), int'(tbl[i].dat));
            if (tbl[i].loads > 0)
                check($sformatf("vec%0d_data_at_load", i), int'(pdata), int'(tbl[i].dat));
        end

        press_start(seen);
        check("cook_enter", seen, 1);
        wait_en(n);
        check("en_at_10", n, 10);
        wait_en(n);
        check("en_at_20", n, 10);
        wait_en(n);
        check("en_at_30", n, 10);

        // door open lands on the DUT (after sync) while presc = 6
        repeat (4) @(negedge clock);
        door_closed = 1'b0;
        repeat (3) @(negedge clock);
        check("pause_cooking", int'(cooking), 0);
        check("pause_en", int'(en), 0);
        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (en) en_cnt++;
        end
        check("pause_en_held", en_cnt, 0);
        door_closed = 1'b1;
        repeat (3) @(negedge clock);
        press_start(seen);
        check("resume_cook", seen, 1);
        wait_en(n);
        check("resume_en_gap", n, 4);

        repeat (9) @(negedge clock);
        timer_zero = 1'b1;
        @(negedge clock);
        check("zero_wrap_en", int'(en), 0);
        check("zero_done", int'(done), 1);
        check("zero_cooking", int'(cooking), 0);
        en_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (en) en_cnt++;
        end
        check("done_en_quiet", en_cnt, 0);
        check("done_held", int'(done), 1);

        clears = 0;
        stop_n = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (!timer_clrn) clears++;
            if (i == 10) stop_n = 1'b1;
        end
        check("done_stop_clears", clears, 1);
        check("done_stop_done", int'(done), 0);
        check("done_stop_cooking", int'(cooking), 0);
        check("done_stop_data", int'(data), 0);
        timer_zero = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
